muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the KGP-RISC datapath, run beside the single-cycle ALU.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Start/busy/done handshake and operand/result bus of the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV unit: shift-add multiply, restoring divide,
// one bit per clock, sign fix-up in a single ADJUST cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ADJUST,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_a_raw;
    logic               w_bzero;

    assign w_accept = bus.start &&
                      (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == LAST);

    // Signed ops work on magnitudes; signs are kept for ADJUST.
    assign w_a_neg  = bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg  = bus.op[0] & bus.b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b  = w_b_neg ? -bus.b : bus.b;

    // Multiply step: add multiplicand on LSB, shift pair right.
    assign w_add    = r_acc_lo[0] ? r_opa : '0;
    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_add};

    // Divide step: shift in next dividend bit, trial subtract.
    assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_opb};
    assign w_ge     = (w_shift >= {1'b0, r_opb});

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quo      = (r_sa ^ r_sb) ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_sa ? -r_acc_hi : r_acc_hi;
    assign w_a_raw    = r_sa ? -r_opa : r_opa;
    assign w_bzero    = (r_opb == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DONE can chain straight into CALC.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_CALC;
            S_CALC:   if (w_last) w_next = S_ADJUST;
            S_ADJUST: w_next = S_DONE;
            S_DONE:   w_next = w_accept ? S_CALC : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_acc_hi <= '0;
            r_acc_lo <= bus.op[1] ? w_abs_a : w_abs_b;
            r_is_div <= bus.op[1];
            r_sa     <= w_a_neg;
            r_sb     <= w_b_neg;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
                r_acc_hi <= w_ge ? w_diff[WIDTH-1:0]
                                 : w_shift[WIDTH-1:0];
                r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
            end else begin
                r_acc_hi <= w_sum[WIDTH:1];
                r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
            end
        end else if (r_state == S_ADJUST) begin
            if (!r_is_div) begin
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
                r_dz <= 1'b0;
            end else if (w_bzero) begin
                r_hi <= w_a_raw;
                r_lo <= '1;
                r_dz <= 1'b1;
            end else begin
                r_hi <= w_rem;
                r_lo <= w_quo;
                r_dz <= 1'b0;
            end
        end
    end

    assign bus.busy     = (r_state == S_CALC) ||
                          (r_state == S_ADJUST);
    assign bus.done     = (r_state == S_DONE);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Each scenario task drives vectors and checks results inline.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    muldiv_if #(.WIDTH(32)) if32 ();
    muldiv_if #(.WIDTH(8))  if8 ();

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    muldiv_unit #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    always #5 clk = ~clk;

    task automatic run32(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int n);
        @(negedge clk);
        if32.start = 1'b1;
        if32.op    = op;
        if32.a     = a;
        if32.b     = b;
        @(posedge clk);
        #1 if32.start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (if32.done) break;
        end
    endtask

    task automatic run8(input logic [1:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        output int n);
        @(negedge clk);
        if8.start = 1'b1;
        if8.op    = op;
        if8.a     = a;
        if8.b     = b;
        @(posedge clk);
        #1 if8.start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (if8.done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if32.busy, if32.done, if32.div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags32 got=%b exp=000",
                     {if32.busy, if32.done, if32.div_zero});
        end
        checks++;
        if ({if32.hi, if32.lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo32 got=%h exp=0",
                     {if32.hi, if32.lo});
        end
        checks++;
        if ({if8.busy, if8.done, if8.div_zero, if8.hi, if8.lo}
            !== 19'h0) begin
            errors++;
            $display("FAIL reset_all8 got=%h exp=0",
                     {if8.busy, if8.done, if8.div_zero,
                      if8.hi, if8.lo});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mulu;
        int n;
        run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL mulu_latency got=%0d exp=33", n);
        end
        checks++;
        if ({if32.hi, if32.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL mulu_max got=%h exp=fffffffe00000001",
                     {if32.hi, if32.lo});
        end
        checks++;
        if (if32.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done got=%b exp=0", if32.busy);
        end
    endtask

    task automatic test_mul_signed;
        int n;
        run32(2'b01, 32'hFFFF_FFFD, 32'd7, n);
        checks++;
        if ({if32.hi, if32.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mul_neg3x7 got=%h exp=ffffffffffffffeb",
                     {if32.hi, if32.lo});
        end
        run32(2'b01, 32'h8000_0000, 32'h8000_0000, n);
        checks++;
        if ({if32.hi, if32.lo} !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL mul_minxmin got=%h exp=4000000000000000",
                     {if32.hi, if32.lo});
        end
    endtask

    task automatic test_div;
        int n;
        run32(2'b11, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL div_latency got=%0d exp=33", n);
        end
        checks++;
        if ({if32.hi, if32.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg7by2 got=%h exp=fffffffffffffffd",
                     {if32.hi, if32.lo});
        end
        run32(2'b10, 32'd100, 32'd7, n);
        checks++;
        if ({if32.hi, if32.lo} !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL divu_100by7 got=%h exp=%h",
                     {if32.hi, if32.lo}, {32'd2, 32'd14});
        end
    endtask

    task automatic test_div_zero;
        int n;
        run32(2'b10, 32'd100, 32'd0, n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL dz_latency got=%0d exp=33", n);
        end
        checks++;
        if ({if32.div_zero, if32.hi, if32.lo}
            !== {1'b1, 32'h64, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL divu_by0 got=%h exp=%h",
                     {if32.div_zero, if32.hi, if32.lo},
                     {1'b1, 32'h64, 32'hFFFF_FFFF});
        end
        run32(2'b00, 32'd2, 32'd3, n);
        checks++;
        if ({if32.div_zero, if32.hi, if32.lo}
            !== {1'b0, 32'd0, 32'd6}) begin
            errors++;
            $display("FAIL dz_clear got=%h exp=%h",
                     {if32.div_zero, if32.hi, if32.lo},
                     {1'b0, 32'd0, 32'd6});
        end
        run32(2'b11, 32'hFFFF_FFF9, 32'd0, n);
        checks++;
        if ({if32.div_zero, if32.hi, if32.lo}
            !== {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL div_by0_raw_a got=%h exp=%h",
                     {if32.div_zero, if32.hi, if32.lo},
                     {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_div_overflow;
        int n;
        run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++;
        if ({if32.div_zero, if32.hi, if32.lo}
            !== {1'b0, 32'd0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL div_min_by_m1 got=%h exp=%h",
                     {if32.div_zero, if32.hi, if32.lo},
                     {1'b0, 32'd0, 32'h8000_0000});
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        int both;
        @(negedge clk);
        if32.start = 1'b1;
        if32.op    = 2'b00;
        if32.a     = 32'd5;
        if32.b     = 32'd6;
        @(posedge clk);
        #1 if32.start = 1'b0;
        n = 0;
        both = 0;
        while (n < 100) begin
            if (n == 5) begin
                @(negedge clk);
                if32.start = 1'b1;
                if32.op    = 2'b10;
                if32.a     = 32'd9;
                if32.b     = 32'd3;
            end
            @(posedge clk);
            n++;
            #1 if32.start = 1'b0;
            if (if32.busy && if32.done) both++;
            if (if32.done) break;
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL busy_start_latency got=%0d exp=33", n);
        end
        checks++;
        if ({if32.hi, if32.lo} !== {32'd0, 32'd30}) begin
            errors++;
            $display("FAIL busy_start_ignored got=%h exp=%h",
                     {if32.hi, if32.lo}, {32'd0, 32'd30});
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL busy_and_done got=%0d exp=0", both);
        end
    endtask

    task automatic test_operand_change;
        int n;
        @(negedge clk);
        if32.start = 1'b1;
        if32.op    = 2'b10;
        if32.a     = 32'd100;
        if32.b     = 32'd7;
        @(posedge clk);
        #1 if32.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if32.op = 2'b01;
        if32.a  = 32'hDEAD_BEEF;
        if32.b  = 32'd0;
        n = 3;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (if32.done) break;
        end
        checks++;
        if ({if32.div_zero, if32.hi, if32.lo}
            !== {1'b0, 32'd2, 32'd14}) begin
            errors++;
            $display("FAIL operand_change got=%h exp=%h",
                     {if32.div_zero, if32.hi, if32.lo},
                     {1'b0, 32'd2, 32'd14});
        end
    endtask

    task automatic test_reset_mid_op;
        int n;
        int seen;
        run32(2'b10, 32'd100, 32'd0, n);
        checks++;
        if (if32.div_zero !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_dz got=%b exp=1", if32.div_zero);
        end
        @(negedge clk);
        if32.start = 1'b1;
        if32.op    = 2'b00;
        if32.a     = 32'h0000_FFFF;
        if32.b     = 32'h0000_FFFF;
        @(posedge clk);
        #1 if32.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({if32.busy, if32.done, if32.div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_flags got=%b exp=000",
                     {if32.busy, if32.done, if32.div_zero});
        end
        checks++;
        if ({if32.hi, if32.lo} !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_hilo got=%h exp=0",
                     {if32.hi, if32.lo});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (if32.done || if32.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got=%0d exp=0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        run32(2'b00, 32'd7, 32'd9, n);
        checks++;
        if ({if32.hi, if32.lo} !== {32'd0, 32'd63}) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h",
                     {if32.hi, if32.lo}, {32'd0, 32'd63});
        end
        if32.start = 1'b1;
        if32.op    = 2'b11;
        if32.a     = 32'd100;
        if32.b     = 32'hFFFF_FFF9;
        @(posedge clk);
        #1 if32.start = 1'b0;
        checks++;
        if (if32.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b exp=1", if32.busy);
        end
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (if32.done) break;
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL b2b_latency got=%0d exp=33", n);
        end
        checks++;
        if ({if32.hi, if32.lo} !== {32'd2, 32'hFFFF_FFF2}) begin
            errors++;
            $display("FAIL b2b_second got=%h exp=%h",
                     {if32.hi, if32.lo}, {32'd2, 32'hFFFF_FFF2});
        end
    endtask

    task automatic test_width8;
        int n;
        run8(2'b00, 8'hFF, 8'hFF, n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL w8_latency got=%0d exp=9", n);
        end
        checks++;
        if ({if8.hi, if8.lo} !== 16'hFE01) begin
            errors++;
            $display("FAIL w8_mulu got=%h exp=fe01", {if8.hi, if8.lo});
        end
        run8(2'b01, 8'hFD, 8'h07, n);
        checks++;
        if ({if8.hi, if8.lo} !== 16'hFFEB) begin
            errors++;
            $display("FAIL w8_mul got=%h exp=ffeb", {if8.hi, if8.lo});
        end
        run8(2'b01, 8'h80, 8'h80, n);
        checks++;
        if ({if8.hi, if8.lo} !== 16'h4000) begin
            errors++;
            $display("FAIL w8_mul_min got=%h exp=4000",
                     {if8.hi, if8.lo});
        end
        run8(2'b11, 8'hF9, 8'h02, n);
        checks++;
        if ({if8.hi, if8.lo} !== 16'hFFFD) begin
            errors++;
            $display("FAIL w8_div got=%h exp=fffd", {if8.hi, if8.lo});
        end
        run8(2'b10, 8'd100, 8'd7, n);
        checks++;
        if ({if8.hi, if8.lo} !== 16'h020E) begin
            errors++;
            $display("FAIL w8_divu got=%h exp=020e", {if8.hi, if8.lo});
        end
        run8(2'b10, 8'd100, 8'd0, n);
        checks++;
        if ({if8.div_zero, if8.hi, if8.lo} !== 17'h164FF) begin
            errors++;
            $display("FAIL w8_div0 got=%h exp=164ff",
                     {if8.div_zero, if8.hi, if8.lo});
        end
        run8(2'b00, 8'd2, 8'd3, n);
        checks++;
        if ({if8.div_zero, if8.hi, if8.lo} !== 17'h00006) begin
            errors++;
            $display("FAIL w8_dz_clear got=%h exp=00006",
                     {if8.div_zero, if8.hi, if8.lo});
        end
        run8(2'b11, 8'h80, 8'hFF, n);
        checks++;
        if ({if8.div_zero, if8.hi, if8.lo} !== 17'h00080) begin
            errors++;
            $display("FAIL w8_div_ovf got=%h exp=00080",
                     {if8.div_zero, if8.hi, if8.lo});
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        errors     = 0;
        checks     = 0;
        if32.start = 1'b0;
        if32.op    = 2'b00;
        if32.a     = '0;
        if32.b     = '0;
        if8.start  = 1'b0;
        if8.op     = 2'b00;
        if8.a      = '0;
        if8.b      = '0;
        test_reset;
        test_mulu;
        test_mul_signed;
        test_div;
        test_div_zero;
        test_div_overflow;
        test_start_while_busy;
        test_operand_change;
        test_reset_mid_op;
        test_back_to_back;
        test_width8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
